vga_sync_gen: RTL and testbench

// Free-running 640x480@60 Hz VGA timing generator. Runs one pixel per i_Clk (25.175/25 MHz).

---
 rtl/vga_sync_gen.sv | 117 +++++++++++
 tb/tb_vga_sync_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_gen
//  Description : Free-running 640x480@60 Hz VGA timing generator, one pixel
//                per clock. Supplies pixel coordinates, the active-video flag,
//                active-low HSync/VSync and a once-per-frame tick.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_Clk         in   1   pixel clock, all logic on the rising edge
//    i_Rst_n       in   1   asynchronous active-low reset
//    pixel_x       out  10  horizontal count, 0..H_TOTAL-1
//    pixel_y       out  10  vertical count,   0..V_TOTAL-1
//    display_area  out  1   high while (pixel_x,pixel_y) is a visible pixel
//    o_HSync       out  1   active-low horizontal sync
//    o_VSync       out  1   active-low vertical sync
//    o_Frame_Tick  out  1   one-cycle pulse at pixel (0,0) of every frame
// ============================================================================
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       display_area,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic       o_Frame_Tick
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] c_H_LAST = 10'(c_H_TOTAL - 1);
  localparam logic [9:0] c_V_LAST = 10'(c_V_TOTAL - 1);

  // Region bounds are held at 11 bits: a sync pulse that ends exactly at a
  // 1024-count total would not fit in the 10-bit counter width.
  localparam logic [10:0] c_H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] c_HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] c_V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] c_VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] r_h;
  logic [9:0] r_v;
  logic       r_de;
  logic       r_hs_n;
  logic       r_vs_n;
  logic       r_tick;

  logic        w_h_wrap;
  logic        w_v_wrap;
  logic [9:0]  w_h_next;
  logic [9:0]  w_v_next;
  logic [10:0] w_h_ext;
  logic [10:0] w_v_ext;
  logic        w_de_next;
  logic        w_hs_n_next;
  logic        w_vs_n_next;
  logic        w_tick_next;

  // Next counter values.
  assign w_h_wrap = (r_h == c_H_LAST);
  assign w_v_wrap = (r_v == c_V_LAST);
  assign w_h_next = w_h_wrap ? 10'd0 : (r_h + 10'd1);
  assign w_v_next = !w_h_wrap ? r_v :
                    (w_v_wrap ? 10'd0 : (r_v + 10'd1));

  assign w_h_ext = {1'b0, w_h_next};
  assign w_v_ext = {1'b0, w_v_next};

  // Flags are decoded from the *next* coordinates so that, once registered,
  // they describe the same pixel as the registered coordinates.
  assign w_de_next   = (w_h_ext < c_H_ACT_END) && (w_v_ext < c_V_ACT_END);
  assign w_hs_n_next = !((w_h_ext >= c_HS_START) && (w_h_ext < c_HS_END));
  assign w_vs_n_next = !((w_v_ext >= c_VS_START) && (w_v_ext < c_VS_END));
  assign w_tick_next = (w_h_next == 10'd0) && (w_v_next == 10'd0);

  // Reset parks the generator on the last blanking pixel of a frame, so the
  // first edge after release lands on (0,0) and raises the frame tick.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_h    <= c_H_LAST;
      r_v    <= c_V_LAST;
      r_de   <= 1'b0;
      r_hs_n <= 1'b1;
      r_vs_n <= 1'b1;
      r_tick <= 1'b0;
    end else begin
      r_h    <= w_h_next;
      r_v    <= w_v_next;
      r_de   <= w_de_next;
      r_hs_n <= w_hs_n_next;
      r_vs_n <= w_vs_n_next;
      r_tick <= w_tick_next;
    end
  end

  assign pixel_x      = r_h;
  assign pixel_y      = r_v;
  assign display_area = r_de;
  assign o_HSync      = r_hs_n;
  assign o_VSync      = r_vs_n;
  assign o_Frame_Tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_gen
//  Description : Self-checking bench for vga_sync_gen. A full-size instance
//                covers reset, line timing and an async mid-line reset; a
//                reduced-timing instance covers whole frames, wraps, tick
//                spacing and randomly placed async resets. Expected outputs
//                come from a closed-form function of edges since release.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_sync_gen;

  // Full-size timing (instance 0)
  localparam int F_HA = 640, F_HFP = 16, F_HS = 96, F_HBP = 48;
  localparam int F_VA = 480, F_VFP = 10, F_VS = 2,  F_VBP = 33;
  // Reduced timing (instance 1) so several whole frames fit the run
  localparam int S_HA = 40,  S_HFP = 4,  S_HS = 8,  S_HBP = 6;
  localparam int S_VA = 20,  S_VFP = 3,  S_VS = 2,  S_VBP = 4;
  localparam int S_HT  = S_HA + S_HFP + S_HS + S_HBP;   // 58
  localparam int S_VT  = S_VA + S_VFP + S_VS + S_VBP;   // 29
  localparam int S_TOT = S_HT * S_VT;                   // 1682

  logic i_Clk = 1'b0;
  logic rst_f_n, rst_s_n;

  logic [9:0] px_f, py_f, px_s, py_s;
  logic de_f, hs_f, vs_f, tk_f;
  logic de_s, hs_s, vs_s, tk_s;

  always #5 i_Clk = ~i_Clk;

  vga_sync_gen dut_full (
    .i_Clk(i_Clk), .i_Rst_n(rst_f_n),
    .pixel_x(px_f), .pixel_y(py_f), .display_area(de_f),
    .o_HSync(hs_f), .o_VSync(vs_f), .o_Frame_Tick(tk_f)
  );

  vga_sync_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
  ) dut_small (
    .i_Clk(i_Clk), .i_Rst_n(rst_s_n),
    .pixel_x(px_s), .pixel_y(py_s), .display_area(de_s),
    .o_HSync(hs_s), .o_VSync(vs_s), .o_Frame_Tick(tk_s)
  );

  int n_checks = 0;
  int n_errors = 0;
  int k_cnt [2];   // rising edges seen with reset released, per instance

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: after k edges the generator sits at raster index
  // (k-1) mod frame_size; k=0 (reset) is the index just before 0.
  function automatic void ref_model(input int d, input int k,
                                    output int x, output int y,
                                    output int de, output int hs,
                                    output int vs, output int tk);
    int ha, hfp, hsw, ht, va, vfp, vsw, vt, idx;
    ha  = d ? S_HA  : F_HA;   hfp = d ? S_HFP : F_HFP;
    hsw = d ? S_HS  : F_HS;   ht  = ha + hfp + hsw + (d ? S_HBP : F_HBP);
    va  = d ? S_VA  : F_VA;   vfp = d ? S_VFP : F_VFP;
    vsw = d ? S_VS  : F_VS;   vt  = va + vfp + vsw + (d ? S_VBP : F_VBP);
    idx = (k + ht * vt - 1) % (ht * vt);
    x  = idx % ht;
    y  = idx / ht;
    de = (x < ha && y < va) ? 1 : 0;
    hs = (x >= ha + hfp && x < ha + hfp + hsw) ? 0 : 1;
    vs = (y >= va + vfp && y < va + vfp + vsw) ? 0 : 1;
    tk = (idx == 0 && k > 0) ? 1 : 0;
  endfunction

  task automatic check_dut(input int d);
    int x, y, de, hs, vs, tk;
    string p;
    ref_model(d, k_cnt[d], x, y, de, hs, vs, tk);
    p = $sformatf("%s@k%0d", d ? "s" : "f", k_cnt[d]);
    if (d == 0) begin
      chk({p, ".x"},  int'(px_f), x);  chk({p, ".y"},  int'(py_f), y);
      chk({p, ".de"}, int'(de_f), de); chk({p, ".hs"}, int'(hs_f), hs);
      chk({p, ".vs"}, int'(vs_f), vs); chk({p, ".tk"}, int'(tk_f), tk);
    end else begin
      chk({p, ".x"},  int'(px_s), x);  chk({p, ".y"},  int'(py_s), y);
      chk({p, ".de"}, int'(de_s), de); chk({p, ".hs"}, int'(hs_s), hs);
      chk({p, ".vs"}, int'(vs_s), vs); chk({p, ".tk"}, int'(tk_s), tk);
    end
  endtask

  // One clock: wait for the edge, account for it, sample 1 time unit later.
  task automatic step();
    @(posedge i_Clk);
    if (rst_f_n) k_cnt[0]++;
    if (rst_s_n) k_cnt[1]++;
    #1;
  endtask

  // Async reset between edges, hold for a random number of edges, release.
  task automatic do_reset(input int d);
    int dly, hold;
    dly  = int'($urandom_range(1, 3));
    hold = int'($urandom_range(1, 4));
    #(dly);
    if (d == 0) rst_f_n = 1'b0; else rst_s_n = 1'b0;
    k_cnt[d] = 0;
    #1;
    check_dut(d);                       // must already be at reset values
    for (int i = 0; i < hold; i++) begin
      step();
      check_dut(d);                     // no tick while held
    end
    if (d == 0) rst_f_n = 1'b1; else rst_s_n = 1'b1;
    step();
    check_dut(d);
    chk($sformatf("%s.tick_after_release", d ? "s" : "f"),
        int'(d ? tk_s : tk_f), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_low_cnt, hs_first_x, de_drop_x, ticks, vs_low_cnt, x, y, d1, d2, d3, d4;
    bit found;
    rst_f_n = 1'b0;
    rst_s_n = 1'b0;
    k_cnt[0] = 0;
    k_cnt[1] = 0;
    step();
    step();
    check_dut(0);
    check_dut(1);
    rst_f_n = 1'b1;
    rst_s_n = 1'b1;

    // Three small frames; full instance checked over its first ~3 lines.
    hs_low_cnt = 0; hs_first_x = -1; de_drop_x = -1; ticks = 0; vs_low_cnt = 0;
    while (k_cnt[1] < 3 * S_TOT) begin
      step();
      if (k_cnt[0] <= 2500) check_dut(0);
      check_dut(1);
      if (k_cnt[0] <= 800) begin
        if (!hs_f) begin
          if (hs_first_x < 0) hs_first_x = int'(px_f);
          hs_low_cnt++;
        end
        if (!de_f && de_drop_x < 0) de_drop_x = int'(px_f);
      end
      if (tk_s) ticks++;
      if (k_cnt[1] <= S_TOT && !vs_s) vs_low_cnt++;
    end
    chk("f.hs_low_cycles", hs_low_cnt, F_HS);
    chk("f.hs_first_low_x", hs_first_x, F_HA + F_HFP);
    chk("f.de_drop_x", de_drop_x, F_HA);
    chk("s.ticks_3_frames", ticks, 3);
    chk("s.vs_low_cycles", vs_low_cnt, S_VS * S_HT);

    // Async reset on the full instance at pixel_x = 300.
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      ref_model(0, k_cnt[0] + 1, x, y, d1, d2, d3, d4);
      if (x == 300) found = 1;
      step();
    end
    chk("f.reach_x300", int'(found), 1);
    chk("f.at_x300", int'(px_f), 300);
    do_reset(0);

    // Async reset on the small instance at (30,10).
    found = 0;
    for (int i = 0; i < 2 * S_TOT && !found; i++) begin
      ref_model(1, k_cnt[1] + 1, x, y, d1, d2, d3, d4);
      if (x == 30 && y == 10) found = 1;
      step();
      check_dut(1);
    end
    chk("s.reach_30_10", int'(found), 1);
    do_reset(1);

    // Randomly placed async resets.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(1, 3000));
      for (int i = 0; i < n; i++) begin
        step();
        check_dut(1);
      end
      do_reset(1);
    end

    // Two further frames from a fresh release, every output every cycle.
    do_reset(1);
    ticks = 1;  // the release edge already produced the first tick
    for (int i = 0; i < 2 * S_TOT + 2; i++) begin
      step();
      check_dut(1);
      if (tk_s && k_cnt[1] <= 2 * S_TOT) ticks++;
    end
    chk("s.ticks_2_frames", ticks, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
